// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU byte-stream sequencer: state encoding, load
// strobes and the ALU opcode set used by benches and higher-level sequencing.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4,
    SEND    = 3'd5
  } seq_state_t;

  localparam logic [2:0] LOAD_NONE = 3'b000;
  localparam logic [2:0] LOAD_A    = 3'b001;
  localparam logic [2:0] LOAD_B    = 3'b010;
  localparam logic [2:0] LOAD_OP   = 3'b100;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

  // Strobe raised for the byte accepted in a receive state.
  function automatic logic [2:0] load_strobe(input seq_state_t s);
    case (s)
      RX_A:    return LOAD_A;
      RX_B:    return LOAD_B;
      RX_OP:   return LOAD_OP;
      default: return LOAD_NONE;
    endcase
  endfunction

  function automatic seq_state_t next_rx_state(input seq_state_t s);
    case (s)
      RX_A:    return RX_B;
      RX_B:    return RX_OP;
      default: return SETTLE;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_timeout_counter.sv
// Inter-byte gap timer. Counts enabled cycles and flags expiry on the cycle
// the count reaches TIMEOUT_CYCLES-1; TIMEOUT_CYCLES = 0 never expires.
module seq_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned NB_TIMER       = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [NB_TIMER-1:0] LIMIT =
    NB_TIMER'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic ACTIVE = (TIMEOUT_CYCLES != 0);

  logic [NB_TIMER-1:0] count;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset || clear) begin
      count <= '0;
    end else if (enable && ACTIVE && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Qualified by enable so a byte arriving on the expiry cycle wins.
  assign expired = ACTIVE && enable && (count == LIMIT);

endmodule

// File: rtl/alu_sequencer.sv
// Byte-stream front end for the 8-bit ALU: loads A, B and opcode from three
// received bytes, captures the result and offers it with valid/ready.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned NB_TIMER       = 20
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_alu_data,
  output logic [2:0]         o_alu_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_timeout,
  output logic               o_overrun
);

  seq_state_t state;
  logic       waiting;
  logic       receiving;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_expired;

  // NOTE: every signal written here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    waiting      = (state == RX_B) || (state == RX_OP);
    receiving    = waiting || (state == RX_A);
    timer_enable = waiting && !i_rx_valid;
    timer_clear  = !waiting || i_rx_valid || timer_expired;
  end

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NB_TIMER      (NB_TIMER)
  ) u_timeout (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= RX_A;
      o_alu_data  <= '0;
      o_alu_valid <= LOAD_NONE;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_alu_valid <= LOAD_NONE;
      o_timeout   <= 1'b0;

      if (i_rx_valid && !receiving) begin
        o_overrun <= 1'b1;
      end

      case (state)
        RX_A, RX_B, RX_OP: begin
          if (i_rx_valid) begin
            o_alu_data  <= i_rx_data;
            o_alu_valid <= load_strobe(state);
            state       <= next_rx_state(state);
          end else if (timer_expired) begin
            // Partial transaction abandoned; stale ALU operands get reloaded.
            state     <= RX_A;
            o_timeout <= 1'b1;
          end
        end
        SETTLE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          o_tx_data  <= i_alu_result;
          o_tx_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= RX_A;
          end
        end
        default: begin
          state <= RX_A;
        end
      endcase
    end
  end

endmodule
